// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_arbiter
// Description : Per-channel rising/falling edge detector with one pending
//               event slot per channel, serialised round-robin onto a single
//               valid/ready event stream. Dropped events set sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
    parameter int CHANNELS    = 4,
    parameter int INDEX_WIDTH = $clog2(CHANNELS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    signals,
    input  logic [CHANNELS-1:0]    rising_enable,
    input  logic [CHANNELS-1:0]    falling_enable,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [INDEX_WIDTH-1:0] event_channel,
    output logic                   event_rising,
    output logic [CHANNELS-1:0]    overflow,
    input  logic                   overflow_clear
);

    // Channel count and last index at the widths used by the wrap arithmetic.
    localparam logic [INDEX_WIDTH:0]   c_channels = (INDEX_WIDTH+1)'(CHANNELS);
    localparam logic [INDEX_WIDTH-1:0] c_last     = INDEX_WIDTH'(CHANNELS - 1);

    logic [CHANNELS-1:0]    r_signals_previous;
    logic [CHANNELS-1:0]    r_pending;
    logic [CHANNELS-1:0]    r_pending_type;
    logic [CHANNELS-1:0]    r_overflow;
    logic [INDEX_WIDTH-1:0] r_pointer;
    logic                   r_event_valid;
    logic [INDEX_WIDTH-1:0] r_event_channel;
    logic                   r_event_rising;

    logic [CHANNELS-1:0]    w_rise;
    logic [CHANNELS-1:0]    w_fall;
    logic [CHANNELS-1:0]    w_edge;
    logic [CHANNELS-1:0]    w_loaded;
    logic [CHANNELS-1:0]    w_drop;
    logic [CHANNELS-1:0]    w_pending_next;
    logic [CHANNELS-1:0]    w_pending_type_next;
    logic                   w_slot_free;
    logic                   w_found;
    logic                   w_load;
    logic [INDEX_WIDTH-1:0] w_sel;
    logic [INDEX_WIDTH:0]   w_idx;
    logic [INDEX_WIDTH-1:0] w_ptr_next;

    assign w_slot_free = !r_event_valid || event_ready;
    assign w_load      = w_slot_free && w_found;
    assign w_ptr_next  = (w_sel == c_last) ? '0 : w_sel + 1'b1;

    // Round-robin search: first pending channel at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_idx = {1'b0, r_pointer} + (INDEX_WIDTH+1)'(i);
            if (w_idx >= c_channels) begin
                w_idx = w_idx - c_channels;
            end
            if (!w_found && r_pending[w_idx[INDEX_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[INDEX_WIDTH-1:0];
            end
        end
    end

    // Per-channel edge detection and pending-slot update. A channel loaded
    // into the output this cycle has a free slot for a same-cycle edge.
    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_channel
            assign w_rise[g]   = signals[g] & ~r_signals_previous[g] & rising_enable[g];
            assign w_fall[g]   = ~signals[g] & r_signals_previous[g] & falling_enable[g];
            assign w_edge[g]   = w_rise[g] | w_fall[g];
            assign w_loaded[g] = w_load && (w_sel == INDEX_WIDTH'(g));
            assign w_drop[g]   = w_edge[g] && r_pending[g] && !w_loaded[g];
            assign w_pending_next[g]      = w_edge[g] ? 1'b1 : (r_pending[g] & ~w_loaded[g]);
            assign w_pending_type_next[g] = (w_edge[g] && !w_drop[g]) ? w_rise[g]
                                                                      : r_pending_type[g];
        end
    endgenerate

    // Input history, pending slots and sticky overflow (set beats clear).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_signals_previous <= '0;
            r_pending          <= '0;
            r_pending_type     <= '0;
            r_overflow         <= '0;
        end else begin
            r_signals_previous <= signals;
            r_pending          <= w_pending_next;
            r_pending_type     <= w_pending_type_next;
            r_overflow         <= (r_overflow & ~{CHANNELS{overflow_clear}}) | w_drop;
        end
    end

    // Output register: load the arbitrated event whenever the slot is free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_event_valid   <= 1'b0;
            r_event_channel <= '0;
            r_event_rising  <= 1'b0;
            r_pointer       <= '0;
        end else if (w_slot_free) begin
            if (w_found) begin
                r_event_valid   <= 1'b1;
                r_event_channel <= w_sel;
                r_event_rising  <= r_pending_type[w_sel];
                r_pointer       <= w_ptr_next;
            end else begin
                r_event_valid   <= 1'b0;
            end
        end
    end

    assign event_valid   = r_event_valid;
    assign event_channel = r_event_channel;
    assign event_rising  = r_event_rising;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_event_arbiter
// Description : Directed self-checking bench for edge_event_arbiter.
//               Outputs are checked and inputs driven on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] signals;
    logic [3:0] rising_enable;
    logic [3:0] falling_enable;
    logic       event_valid;
    logic       event_ready;
    logic [1:0] event_channel;
    logic       event_rising;
    logic [3:0] overflow;
    logic       overflow_clear;

    int checks   = 0;
    int failures = 0;

    edge_event_arbiter #(.CHANNELS(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .signals        (signals),
        .rising_enable  (rising_enable),
        .falling_enable (falling_enable),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_channel  (event_channel),
        .event_rising   (event_rising),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Check the full presented event in one go.
    task automatic check_event(input string tag, input logic v, input logic [1:0] ch, input logic r);
        check({tag, "_valid"}, 32'(event_valid), 32'(v));
        if (v) begin
            check({tag, "_channel"}, 32'(event_channel), 32'(ch));
            check({tag, "_rising"}, 32'(event_rising), 32'(r));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        signals = 4'b0000;
        event_ready = 1'b0;
        overflow_clear = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        signals = 4'b0000;
        rising_enable = 4'b0000;
        falling_enable = 4'b0000;
        event_ready = 1'b0;
        overflow_clear = 1'b0;
        tick(2);
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_channel", 32'(event_channel), 32'd0);
        check("rst_rising", 32'(event_rising), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Single channel: rise then fall on channel 2, rising enable only.
        rising_enable = 4'b0100;
        event_ready = 1'b1;
        tick(1);
        signals = 4'b0100;
        tick(1);
        check_event("single_n1", 1'b0, 2'd0, 1'b0);
        signals = 4'b0000;
        tick(1);
        check_event("single_n2", 1'b1, 2'd2, 1'b1);
        tick(1);
        check_event("single_n3", 1'b0, 2'd0, 1'b0);
        tick(1);
        check_event("single_n4", 1'b0, 2'd0, 1'b0);

        // Fairness: all four rise together, then 0 and 1 again.
        do_reset();
        rising_enable = 4'b1111;
        falling_enable = 4'b0000;
        event_ready = 1'b1;
        signals = 4'b1111;
        tick(1);
        check_event("fair_n1", 1'b0, 2'd0, 1'b0);
        tick(1);
        check_event("fair_ev0", 1'b1, 2'd0, 1'b1);
        signals = 4'b0000;
        tick(1);
        check_event("fair_ev1", 1'b1, 2'd1, 1'b1);
        signals = 4'b0011;
        tick(1);
        check_event("fair_ev2", 1'b1, 2'd2, 1'b1);
        tick(1);
        check_event("fair_ev3", 1'b1, 2'd3, 1'b1);
        tick(1);
        check_event("fair_wrap0", 1'b1, 2'd0, 1'b1);
        tick(1);
        check_event("fair_wrap1", 1'b1, 2'd1, 1'b1);
        tick(1);
        check_event("fair_idle", 1'b0, 2'd0, 1'b0);

        // Backpressure: event held stable while not ready.
        do_reset();
        rising_enable = 4'b1111;
        event_ready = 1'b0;
        signals = 4'b0010;
        tick(1);
        check_event("bp_n1", 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_event("bp_hold", 1'b1, 2'd1, 1'b1);
        end
        event_ready = 1'b1;
        tick(1);
        check_event("bp_consumed", 1'b0, 2'd0, 1'b0);
        event_ready = 1'b0;

        // Overflow: rise presented, fall pending, second rise dropped.
        do_reset();
        rising_enable = 4'b0001;
        falling_enable = 4'b0001;
        event_ready = 1'b0;
        signals = 4'b0001;
        tick(2);
        check_event("ovf_first", 1'b1, 2'd0, 1'b1);
        signals = 4'b0000;
        tick(1);
        check("ovf_none_yet", 32'(overflow), 32'h0);
        signals = 4'b0001;
        tick(1);
        check("ovf_set", 32'(overflow), 32'h1);
        check_event("ovf_still_rise", 1'b1, 2'd0, 1'b1);
        event_ready = 1'b1;
        tick(1);
        check_event("ovf_fall_next", 1'b1, 2'd0, 1'b0);
        tick(1);
        check_event("ovf_empty", 1'b0, 2'd0, 1'b0);
        event_ready = 1'b0;
        overflow_clear = 1'b1;
        tick(1);
        overflow_clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);
        signals = 4'b0000;
        tick(2);
        check_event("ovf_fall2", 1'b1, 2'd0, 1'b0);
        signals = 4'b0001;
        tick(1);
        check("ovf_no_drop_yet", 32'(overflow), 32'h0);
        signals = 4'b0000;
        overflow_clear = 1'b1;
        tick(1);
        overflow_clear = 1'b0;
        check("ovf_set_beats_clear", 32'(overflow), 32'h1);

        // Same-cycle reload on channel 3: no overflow.
        do_reset();
        rising_enable = 4'b1000;
        falling_enable = 4'b1000;
        event_ready = 1'b1;
        signals = 4'b1000;
        tick(1);
        signals = 4'b0000;
        tick(1);
        check_event("reload_rise", 1'b1, 2'd3, 1'b1);
        check("reload_ovf_a", 32'(overflow), 32'h0);
        tick(1);
        check_event("reload_fall", 1'b1, 2'd3, 1'b0);
        check("reload_ovf_b", 32'(overflow), 32'h0);
        tick(1);
        check_event("reload_idle", 1'b0, 2'd0, 1'b0);

        // Reset mid-operation with an event presented and two pending.
        do_reset();
        rising_enable = 4'b1111;
        falling_enable = 4'b0000;
        event_ready = 1'b0;
        signals = 4'b0111;
        tick(2);
        check_event("mrst_before", 1'b1, 2'd0, 1'b1);
        reset = 1'b1;
        signals = 4'b0001;
        #1;
        check("mrst_valid", 32'(event_valid), 32'd0);
        check("mrst_channel", 32'(event_channel), 32'd0);
        check("mrst_rising", 32'(event_rising), 32'd0);
        check("mrst_overflow", 32'(overflow), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check_event("mrst_n1", 1'b0, 2'd0, 1'b0);
        tick(1);
        check_event("mrst_replay", 1'b1, 2'd0, 1'b1);
        event_ready = 1'b1;
        tick(1);
        check_event("mrst_after_a", 1'b0, 2'd0, 1'b0);
        tick(1);
        check_event("mrst_after_b", 1'b0, 2'd0, 1'b0);
        check("mrst_after_ovf", 32'(overflow), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
